// File: rtl/modn_updown_counter_if.sv
// Button, switch and LED signals of the mod-N up/down counter.
// The bench (or board wrapper) drives through master; the counter uses slave.
interface modn_updown_counter_if #(
    parameter int WIDTH = 4
);
    logic             btn_step;
    logic             dir;
    logic             en;
    logic             clr;
    logic [WIDTH-1:0] count;
    logic             carry;
    logic             terminal;

    modport master (
        output btn_step,
        output dir,
        output en,
        output clr,
        input  count,
        input  carry,
        input  terminal
    );

    modport slave (
        input  btn_step,
        input  dir,
        input  en,
        input  clr,
        output count,
        output carry,
        output terminal
    );
endinterface

// File: rtl/modn_updown_counter.sv
// Mod-N up/down counter stepped by a synchronised, debounced push-button,
// with enable, synchronous clear, a registered wrap pulse and a terminal flag.
module modn_updown_counter #(
    parameter int WIDTH           = 4,
    parameter int MODULUS         = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                      clk,
    input  logic                      rst,
    modn_updown_counter_if.slave      bus
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [DW-1:0]    DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0] CNT_LAST  = WIDTH'(MODULUS - 1);

    generate
        if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
            $error("modn_updown_counter: WIDTH must be in 1..16");
        end
        if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
            $error("modn_updown_counter: MODULUS must be in 2..2**WIDTH");
        end
        if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
            $error("modn_updown_counter: DEBOUNCE_CYCLES must be at least 1");
        end
    endgenerate

    logic             s1_q, s2_q;
    logic             db_level_q, db_level_d;
    logic             db_dly_q;
    logic [DW-1:0]    dcnt_q, dcnt_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             carry_q, carry_d;
    logic             press;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= bus.btn_step;
            s2_q <= s1_q;
        end
    end

    // Any bounce back to the accepted level restarts the stable-time count.
    always_comb begin
        db_level_d = db_level_q;
        dcnt_d     = dcnt_q;
        if (s2_q == db_level_q) begin
            dcnt_d = '0;
        end else if (dcnt_q == DCNT_LAST) begin
            db_level_d = ~db_level_q;
            dcnt_d     = '0;
        end else begin
            dcnt_d = dcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_level_q <= 1'b0;
            db_dly_q   <= 1'b0;
            dcnt_q     <= '0;
        end else begin
            db_level_q <= db_level_d;
            db_dly_q   <= db_level_q;
            dcnt_q     <= dcnt_d;
        end
    end

    assign press = db_level_q & ~db_dly_q;

    // Clear beats a same-cycle press; wrap points are explicit compares.
    always_comb begin
        count_d = count_q;
        carry_d = 1'b0;
        if (bus.clr) begin
            count_d = '0;
        end else if (press && bus.en) begin
            if (bus.dir) begin
                if (count_q == CNT_LAST) begin
                    count_d = '0;
                    carry_d = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (count_q == '0) begin
                    count_d = CNT_LAST;
                    carry_d = 1'b1;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            carry_q <= 1'b0;
        end else begin
            count_q <= count_d;
            carry_q <= carry_d;
        end
    end

    assign bus.count    = count_q;
    assign bus.carry    = carry_q;
    assign bus.terminal = bus.dir ? (count_q == CNT_LAST) : (count_q == '0);
endmodule

// File: tb/tb_modn_updown_counter.sv
// Directed bench for modn_updown_counter: MODULUS=10, WIDTH=4, DEBOUNCE_CYCLES=4,
// so an accepted press updates count at the 7th clock edge after the button rises.
module tb_modn_updown_counter;
    localparam int WIDTH = 4;
    localparam int MOD   = 10;
    localparam int DEB   = 4;
    localparam int LAT   = DEB + 3;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    modn_updown_counter_if #(.WIDTH(WIDTH)) bus ();

    modn_updown_counter #(
        .WIDTH(WIDTH),
        .MODULUS(MOD),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             dir;
        logic             en;
        logic             clr;
        logic [WIDTH-1:0] expCount;
        logic             expCarry;
        logic             expTerm;
    } vec_t;

    vec_t vecs[17];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One full press/release with the given switch settings held throughout.
    task automatic applyStimulus(input vec_t v, input logic [WIDTH-1:0] prevCount);
        bus.dir      = v.dir;
        bus.en       = v.en;
        bus.clr      = v.clr;
        bus.btn_step = 1'b1;
        repeat (LAT - 1) tick();
        if (!v.clr) checkOutput("preUpdateCount", int'(bus.count), int'(prevCount));
        tick();
        checkOutput("vecCount", int'(bus.count), int'(v.expCount));
        checkOutput("vecCarry", int'(bus.carry), int'(v.expCarry));
        checkOutput("vecTerminal", int'(bus.terminal), int'(v.expTerm));
        tick();
        checkOutput("carryOneCycle", int'(bus.carry), 0);
        checkOutput("holdCount", int'(bus.count), int'(v.expCount));
        bus.btn_step = 1'b0;
        bus.clr      = 1'b0;
        repeat (LAT + 1) tick();
    endtask

    logic [6:0]       bpat;
    logic [WIDTH-1:0] prev;

    initial begin
        total = 0;
        bad   = 0;

        // {dir, en, clr, expCount, expCarry, expTerm}, starting from count=2
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 4'd4, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 4'd5, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 4'd6, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 4'd7, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 4'd8, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 4'd9, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 4'd9, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 4'd8, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 4'd9, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 4'd8, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 4'd7, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 4'd6, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 4'd5, 1'b0, 1'b0};

        bus.btn_step = 1'b0;
        bus.dir      = 1'b1;
        bus.en       = 1'b1;
        bus.clr      = 1'b0;
        rst          = 1'b1;
        repeat (3) tick();

        $display("[TB] reset state");
        checkOutput("rstCount", int'(bus.count), 0);
        checkOutput("rstCarry", int'(bus.carry), 0);
        checkOutput("rstTerminalUp", int'(bus.terminal), 0);
        bus.dir = 1'b0;
        #1;
        checkOutput("rstTerminalDown", int'(bus.terminal), 1);
        bus.dir = 1'b1;

        $display("[TB] button held from reset release");
        bus.btn_step = 1'b1;
        rst          = 1'b0;
        repeat (LAT - 1) tick();
        checkOutput("heldPreCount", int'(bus.count), 0);
        tick();
        checkOutput("heldCount", int'(bus.count), 1);
        checkOutput("heldCarry", int'(bus.carry), 0);
        repeat (20) tick();
        checkOutput("heldNoRepeat", int'(bus.count), 1);
        bus.btn_step = 1'b0;
        repeat (LAT + 1) tick();

        $display("[TB] bouncy press");
        bpat = 7'b1111011;
        for (int i = 0; i < 7; i++) begin
            bus.btn_step = bpat[i];
            tick();
        end
        repeat (2) tick();
        checkOutput("bouncePreCount", int'(bus.count), 1);
        tick();
        checkOutput("bounceCount", int'(bus.count), 2);
        repeat (20) tick();
        checkOutput("bounceSingleStep", int'(bus.count), 2);
        bus.btn_step = 1'b0;
        repeat (LAT + 1) tick();

        $display("[TB] vector table");
        prev = 4'd2;
        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i], prev);
            prev = vecs[i].expCount;
        end

        $display("[TB] reset during debounce");
        bus.dir      = 1'b1;
        bus.btn_step = 1'b1;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        checkOutput("asyncRstCount", int'(bus.count), 0);
        checkOutput("asyncRstCarry", int'(bus.carry), 0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (LAT - 1) tick();
        checkOutput("postRstPreCount", int'(bus.count), 0);
        tick();
        checkOutput("postRstCount", int'(bus.count), 1);
        checkOutput("postRstCarry", int'(bus.carry), 0);
        bus.btn_step = 1'b0;
        repeat (LAT + 1) tick();

        $display("[TB] clear in the press cycle");
        bus.btn_step = 1'b1;
        repeat (LAT - 1) tick();
        bus.clr = 1'b1;
        tick();
        checkOutput("clrPressCount", int'(bus.count), 0);
        checkOutput("clrPressCarry", int'(bus.carry), 0);
        bus.clr = 1'b0;
        tick();
        checkOutput("clrPressLost", int'(bus.count), 0);
        bus.btn_step = 1'b0;
        repeat (LAT + 1) tick();

        $display("[TB] terminal follows dir");
        bus.dir = 1'b1;
        #1;
        checkOutput("termDirUpAtZero", int'(bus.terminal), 0);
        bus.dir = 1'b0;
        #1;
        checkOutput("termDirDownAtZero", int'(bus.terminal), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/modn_updown_counter.md
# modn_updown_counter

Parametrised successor to the board-level mod-4 button counter: a synchronous, clocked mod-N up/down counter stepped by a debounced push-button. It targets the EGO1 lab board, where a raw button and slide switches drive it and its outputs go straight to LEDs. It adds what the button-clocked version lacks: a single clock domain, input synchronisation and debounce, configurable modulus and width, count direction, enable, synchronous clear, and a registered wrap pulse.

## Interface
- WIDTH, 4: count register width; legal range 1..16.
- MODULUS, 4: count sequence length; legal range 2..2^WIDTH. Out-of-range values must stop elaboration.
- DEBOUNCE_CYCLES, 1_000_000: number of stable clk cycles required to accept a button level (10 ms at 100 MHz); legal minimum 1.
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous and active-high.
- btn_step  input  1  raw push-button, asynchronous to clk and bouncy; a press (0→1) steps the counter.
- dir  input  1  slide switch: 1 counts up, 0 counts down. Quasi-static and sampled directly.
- en  input  1  slide switch: 1 lets accepted presses step the counter.
- clr  input  1  synchronous clear, level, sampled directly.
- count  output  WIDTH  current count, registered.
- carry  output  1  one-cycle pulse on wrap, registered.
- terminal  output  1  combinational: count==MODULUS-1 when dir=1; count==0 when dir=0.

## Operation
- **Synchroniser:** two flops s1→s2 on btn_step. Both reset to 0.
- **Debounce:**
  - Registers db (accepted level) and dcnt (width clog2(DEBOUNCE_CYCLES)+1).
  - When s2==db, dcnt is cleared to 0.
  - When s2!=db and dcnt==DEBOUNCE_CYCLES-1, db toggles and dcnt is cleared.
  - Otherwise, when s2!=db, dcnt increments.
  - Any bounce back to the db level restarts the stable-time count.
- **Edge detect:** db_q is db delayed one cycle. press = db & ~db_q. Releases never step the counter.
- **Counter update priority:** clr, then (press & en), then hold.
  - clr=1: count←0 and carry←0. This applies even if press is high in the same cycle; that press is lost.
  - press & en & dir=1: if count==MODULUS-1, count←0 and carry←1; else count←count+1 and carry←0.
  - press & en & dir=0: if count==0, count←MODULUS-1 and carry←1; else count←count−1 and carry←0.
  - Otherwise: count holds and carry←0.
- **Out-of-range count:** count never exceeds MODULUS-1. Implementations must not rely on arithmetic overflow; comparisons are explicit.
- **Disabled presses:** a press with en=0 is consumed and discarded. It is not queued.
- **Direction switch:** changing dir takes effect on the next accepted press. terminal follows dir immediately, because it is combinational.

## Timing
- **Reset values:** count=0, carry=0, and s1, s2, db, db_q, dcnt all 0. terminal is therefore 1 if dir=0 and 0 if dir=1 with MODULUS>1.
- **Press latency:** btn_step rises before edge 1 and stays stable:
  - s2=1 after edge 2;
  - dcnt counts from edge 3;
  - db=1 after edge DEBOUNCE_CYCLES+2;
  - press is high for exactly the following cycle;
  - count updates at edge DEBOUNCE_CYCLES+3.
- **carry:** asserted in the same cycle as the updated count, for exactly one cycle.
- **Press rate:** at most one step per accepted press, regardless of how long the button is held.
- **Reset mid-operation:** rst asserted at any time, including mid-debounce, immediately forces all reset values. After release, a held button is seen as a new press once it has been stable for the full latency.
- **Reset release:** deassertion must be synchronous to clk at board level. The block adds no reset synchroniser.

## Test plan
1. DEBOUNCE_CYCLES=4, MODULUS=4, dir=1, en=1; hold btn_step high from reset release → count 0→1 at edge 7; carry stays 0; no further steps while held.
2. DEBOUNCE_CYCLES=4; drive btn_step 1,1,0,1,1,1,1 (bounce) → db does not rise until the final 1 has been stable for 4 cycles after synchronisation; exactly one step.
3. MODULUS=10, WIDTH=4, dir=1; 10 clean presses → count goes 1..9 then 0; carry pulses once, in the cycle count becomes 0; terminal is high while count==9.
4. MODULUS=10, dir=0, from reset; 1 press → count=9 with a carry pulse; 9 more presses → count=0; terminal is high whenever count==0.
5. Press with en=0 → count unchanged. Press with clr=1 in the same cycle as press → count=0, carry=0.
6. Assert rst with count=5 while dcnt is mid-count → count=0 and carry=0 immediately, asynchronously; the button still held after release → one step after the full DEBOUNCE_CYCLES+3 latency.
